// File: rtl/react_timer.sv
// -----------------------------------------------------------------------------
// react_timer
//   Reaction-time measurement stage. Watches the LED drive and the player
//   button, counts milliseconds in 4-digit BCD from the LED turning on to the
//   button press, and holds the result for the display stage. It flags false
//   starts (a press while the LED is dark) and timeouts (no press by MAX_BCD).
//
// Optional feature macro: BEST_TIME_EN
//   When defined, the block tracks the best (smallest) valid time since reset.
//   When undefined, best_bcd is tied to 16'h0000.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   led          in   1   LED drive from the random-LED stage (asynchronous)
//   btn          in   1   player button, active-high, debounced, asynchronous
//   time_bcd     out  16  reaction time {thou,hund,ten,unit} in ms, BCD
//   result_vld   out  1   one-cycle pulse when time_bcd is updated by a press
//   too_slow     out  1   level: last run timed out; cleared at next run start
//   false_start  out  1   one-cycle pulse: button press while idle
//   busy         out  1   level: high while timing
//   best_bcd     out  16  best valid time since reset (0 until first result)
//   dbg_state    out  2   current FSM state (IDLE=0, TIMING=1, DONE=2, TIMEOUT=3)
//
// Handshake: result_vld and false_start are single-cycle strobes with no
//   ready; time_bcd is stable from the cycle result_vld is high until the
//   next run produces a result or timeout.
// -----------------------------------------------------------------------------
module react_timer #(
  parameter int          TICK_DIV = 50000,
  parameter logic [15:0] MAX_BCD  = 16'h9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led,
  input  logic        btn,
  output logic [15:0] time_bcd,
  output logic        result_vld,
  output logic        too_slow,
  output logic        false_start,
  output logic        busy,
  output logic [15:0] best_bcd,
  output logic [1:0]  dbg_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TIMING  = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t state, state_nx;

  // Two synchroniser flops plus one history flop for edge detection.
  logic [2:0] led_sh, btn_sh;
  logic       led_sync, led_rise, btn_rise;

  logic [TW-1:0] tick;
  logic [15:0]   cnt;
  logic          tick_wrap;

  logic start_run, press, timeout, fs_evt;

  // Ripple BCD increment: each digit wraps 9->0 and carries into the next.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_sh <= '0;
      btn_sh <= '0;
    end else begin
      led_sh <= {led_sh[1:0], led};
      btn_sh <= {btn_sh[1:0], btn};
    end
  end

  assign led_sync  = led_sh[1];
  assign led_rise  = led_sh[1] & ~led_sh[2];
  assign btn_rise  = btn_sh[1] & ~btn_sh[2];
  assign tick_wrap = (tick == TW'(TICK_DIV - 1));

  always_comb begin
    state_nx  = state;
    start_run = 1'b0;
    press     = 1'b0;
    timeout   = 1'b0;
    fs_evt    = 1'b0;
    case (state)
      S_IDLE: begin
        // A simultaneous LED rise wins: the run starts, no false start.
        if (led_rise) begin
          start_run = 1'b1;
          state_nx  = S_TIMING;
        end else if (btn_rise) begin
          fs_evt = 1'b1;
        end
      end
      S_TIMING: begin
        // A press in the same cycle as saturation still counts as valid.
        if (btn_rise) begin
          press    = 1'b1;
          state_nx = S_DONE;
        end else if (cnt == MAX_BCD) begin
          timeout  = 1'b1;
          state_nx = S_TIMEOUT;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (!led_sync) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tick        <= '0;
      cnt         <= '0;
      time_bcd    <= '0;
      result_vld  <= 1'b0;
      too_slow    <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_nx;
      result_vld  <= press;
      false_start <= fs_evt;
      if (start_run) begin
        tick     <= '0;
        cnt      <= '0;
        too_slow <= 1'b0;
      end else if (state == S_TIMING) begin
        if (tick_wrap) begin
          tick <= '0;
          if (cnt != MAX_BCD) cnt <= bcd_inc(cnt);
        end else begin
          tick <= tick + TW'(1);
        end
      end
      if (press) time_bcd <= cnt;
      if (timeout) begin
        time_bcd <= MAX_BCD;
        too_slow <= 1'b1;
      end
    end
  end

  assign busy      = (state == S_TIMING);
  assign dbg_state = state;

`ifdef BEST_TIME_EN
  logic [15:0] best_q;
  logic        have_best;

  // For valid BCD digits, an unsigned compare of the packed vector is the
  // same as a digit-wise compare starting at the most significant digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q    <= 16'h9999;
      have_best <= 1'b0;
    end else if (press) begin
      have_best <= 1'b1;
      if (cnt < best_q) best_q <= cnt;
    end
  end

  assign best_bcd = have_best ? best_q : 16'h0000;
`else
  assign best_bcd = 16'h0000;
`endif

endmodule
